// File: rtl/tdp_ram_be.sv
// rtl/tdp_ram_be.sv - true dual-port RAM with byte enables, read-during-write modes and collision flags
// Port A and B share one clock; collisions on the same address are merged per lane and reported.
module tdp_ram_be #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8,
  parameter int BYTE_WIDTH = 8,
  parameter int RDW_MODE   = 0,
  parameter int COLL_PRIO  = 0,
  parameter int OUT_REG    = 0,
  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_a,
  input  logic                  we_a,
  input  logic [NUM_BYTES-1:0]  be_a,
  input  logic [ADDR_WIDTH-1:0] addr_a,
  input  logic [DATA_WIDTH-1:0] din_a,
  output logic [DATA_WIDTH-1:0] dout_a,
  output logic                  dvalid_a,
  input  logic                  en_b,
  input  logic                  we_b,
  input  logic [NUM_BYTES-1:0]  be_b,
  input  logic [ADDR_WIDTH-1:0] addr_b,
  input  logic [DATA_WIDTH-1:0] din_b,
  output logic [DATA_WIDTH-1:0] dout_b,
  output logic                  dvalid_b,
  output logic                  coll_ww,
  output logic                  coll_rw
);

  localparam int   DEPTH    = 2 ** ADDR_WIDTH;
  localparam logic P_B_WINS = (COLL_PRIO == 1);
  localparam logic P_A_WINS = !P_B_WINS;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];

  logic                  w_same_addr;
  logic                  w_ww;
  logic                  w_rw;
  logic [DATA_WIDTH-1:0] w_old_a;
  logic [DATA_WIDTH-1:0] w_old_b;
  logic [NUM_BYTES-1:0]  w_lane_a;
  logic [NUM_BYTES-1:0]  w_lane_b;
  logic [DATA_WIDTH-1:0] w_new_a;
  logic [DATA_WIDTH-1:0] w_new_b;

  logic [DATA_WIDTH-1:0] r_dout1_a;
  logic [DATA_WIDTH-1:0] r_dout1_b;
  logic                  r_dv1_a;
  logic                  r_dv1_b;
  logic                  r_coll_ww;
  logic                  r_coll_rw;

  assign w_same_addr = (addr_a == addr_b);
  assign w_ww        = en_a & we_a & en_b & we_b & w_same_addr;
  assign w_rw        = en_a & en_b & w_same_addr & (we_a ^ we_b);
  assign w_old_a     = r_mem[addr_a];
  assign w_old_b     = r_mem[addr_b];

  // Final per-lane write enables: on a same-address overlap only the priority port keeps the lane.
  always_comb begin
    w_lane_a = '0;
    w_lane_b = '0;
    for (int i = 0; i < NUM_BYTES; i++) begin
      w_lane_a[i] = rst_n & en_a & we_a & be_a[i] & ~(w_ww & be_b[i] & P_B_WINS);
      w_lane_b[i] = rst_n & en_b & we_b & be_b[i] & ~(w_ww & be_a[i] & P_A_WINS);
    end
  end

  // Post-write word as seen by each port; includes the other port's lanes only on a write-write hit.
  always_comb begin
    w_new_a = w_old_a;
    w_new_b = w_old_b;
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (w_lane_a[i]) begin
        w_new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else if (w_ww && w_lane_b[i]) begin
        w_new_a[i*BYTE_WIDTH +: BYTE_WIDTH] = din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (w_lane_b[i]) begin
        w_new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      end else if (w_ww && w_lane_a[i]) begin
        w_new_b[i*BYTE_WIDTH +: BYTE_WIDTH] = din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BYTES; i++) begin
      if (w_lane_a[i]) begin
        r_mem[addr_a][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_a[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
      if (w_lane_b[i]) begin
        r_mem[addr_b][i*BYTE_WIDTH +: BYTE_WIDTH] <= din_b[i*BYTE_WIDTH +: BYTE_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout1_a <= '0;
      r_dv1_a   <= 1'b0;
    end else if (en_a) begin
      if (!we_a) begin
        r_dout1_a <= w_old_a;
        r_dv1_a   <= 1'b1;
      end else if (RDW_MODE == 1) begin
        r_dout1_a <= w_new_a;
        r_dv1_a   <= 1'b1;
      end else if (RDW_MODE == 2) begin
        r_dv1_a   <= 1'b0;
      end else begin
        r_dout1_a <= w_old_a;
        r_dv1_a   <= 1'b1;
      end
    end else begin
      r_dv1_a <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_dout1_b <= '0;
      r_dv1_b   <= 1'b0;
    end else if (en_b) begin
      if (!we_b) begin
        r_dout1_b <= w_old_b;
        r_dv1_b   <= 1'b1;
      end else if (RDW_MODE == 1) begin
        r_dout1_b <= w_new_b;
        r_dv1_b   <= 1'b1;
      end else if (RDW_MODE == 2) begin
        r_dv1_b   <= 1'b0;
      end else begin
        r_dout1_b <= w_old_b;
        r_dv1_b   <= 1'b1;
      end
    end else begin
      r_dv1_b <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_coll_ww <= 1'b0;
      r_coll_rw <= 1'b0;
    end else begin
      r_coll_ww <= w_ww;
      r_coll_rw <= w_rw;
    end
  end

  assign coll_ww = r_coll_ww;
  assign coll_rw = r_coll_rw;

  // The second stage only advances on a valid first stage so dout keeps holding between reads.
  if (OUT_REG != 0) begin : g_out_reg
    logic [DATA_WIDTH-1:0] r_dout2_a;
    logic [DATA_WIDTH-1:0] r_dout2_b;
    logic                  r_dv2_a;
    logic                  r_dv2_b;

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_dout2_a <= '0;
        r_dout2_b <= '0;
        r_dv2_a   <= 1'b0;
        r_dv2_b   <= 1'b0;
      end else begin
        r_dv2_a <= r_dv1_a;
        r_dv2_b <= r_dv1_b;
        if (r_dv1_a) begin
          r_dout2_a <= r_dout1_a;
        end
        if (r_dv1_b) begin
          r_dout2_b <= r_dout1_b;
        end
      end
    end

    assign dout_a   = r_dout2_a;
    assign dout_b   = r_dout2_b;
    assign dvalid_a = r_dv2_a;
    assign dvalid_b = r_dv2_b;
  end else begin : g_no_out_reg
    assign dout_a   = r_dout1_a;
    assign dout_b   = r_dout1_b;
    assign dvalid_a = r_dv1_a;
    assign dvalid_b = r_dv1_b;
  end

endmodule

// File: tb/tb_tdp_ram_be.sv
// tb/tb_tdp_ram_be.sv - directed vector bench for tdp_ram_be across RDW, priority and output-register variants
// Four instances share the stimulus: rf (READ_FIRST), wf (WRITE_FIRST, B priority), nc (NO_CHANGE), orr (OUT_REG).
module tb_tdp_ram_be;

  logic        clk;
  logic        rst_n;
  logic        en_a, we_a, en_b, we_b;
  logic [3:0]  be_a, be_b;
  logic [7:0]  addr_a, addr_b;
  logic [31:0] din_a, din_b;

  logic [31:0] rf_dout_a, rf_dout_b, wf_dout_a, wf_dout_b;
  logic [31:0] nc_dout_a, nc_dout_b, or_dout_a, or_dout_b;
  logic rf_dv_a, rf_dv_b, rf_ww, rf_rw, wf_dv_a, wf_dv_b, wf_ww, wf_rw;
  logic nc_dv_a, nc_dv_b, nc_ww, nc_rw, or_dv_a, or_dv_b, or_ww, or_rw;

  int n_checks = 0;
  int n_fail   = 0;

  tdp_ram_be #(.RDW_MODE(0), .COLL_PRIO(0), .OUT_REG(0)) u_rf (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(rf_dout_a), .dvalid_a(rf_dv_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(rf_dout_b), .dvalid_b(rf_dv_b),
    .coll_ww(rf_ww), .coll_rw(rf_rw)
  );

  tdp_ram_be #(.RDW_MODE(1), .COLL_PRIO(1), .OUT_REG(0)) u_wf (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(wf_dout_a), .dvalid_a(wf_dv_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(wf_dout_b), .dvalid_b(wf_dv_b),
    .coll_ww(wf_ww), .coll_rw(wf_rw)
  );

  tdp_ram_be #(.RDW_MODE(2), .COLL_PRIO(0), .OUT_REG(0)) u_nc (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(nc_dout_a), .dvalid_a(nc_dv_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(nc_dout_b), .dvalid_b(nc_dv_b),
    .coll_ww(nc_ww), .coll_rw(nc_rw)
  );

  tdp_ram_be #(.RDW_MODE(0), .COLL_PRIO(0), .OUT_REG(1)) u_orr (
    .clk(clk), .rst_n(rst_n),
    .en_a(en_a), .we_a(we_a), .be_a(be_a), .addr_a(addr_a), .din_a(din_a),
    .dout_a(or_dout_a), .dvalid_a(or_dv_a),
    .en_b(en_b), .we_b(we_b), .be_b(be_b), .addr_b(addr_b), .din_b(din_b),
    .dout_b(or_dout_b), .dvalid_b(or_dv_b),
    .coll_ww(or_ww), .coll_rw(or_rw)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        en_a, we_a;
    logic [3:0]  be_a;
    logic [7:0]  addr_a;
    logic [31:0] din_a;
    logic        en_b, we_b;
    logic [3:0]  be_b;
    logic [7:0]  addr_b;
    logic [31:0] din_b;
    logic        dv_a, cd_a;
    logic [31:0] dout_a;
    logic        dv_b, cd_b;
    logic [31:0] dout_b;
    logic        ww, rw;
  } vec_t;

  vec_t vecs[16];

  function automatic vec_t mk(input string nm,
      input logic ea, input logic wa, input logic [3:0] ba, input logic [7:0] aa, input logic [31:0] da,
      input logic eb, input logic wb, input logic [3:0] bb, input logic [7:0] ab, input logic [31:0] db,
      input logic xva, input logic xcda, input logic [31:0] xa,
      input logic xvb, input logic xcdb, input logic [31:0] xb,
      input logic xww, input logic xrw);
    vec_t t;
    t.name = nm;
    t.en_a = ea; t.we_a = wa; t.be_a = ba; t.addr_a = aa; t.din_a = da;
    t.en_b = eb; t.we_b = wb; t.be_b = bb; t.addr_b = ab; t.din_b = db;
    t.dv_a = xva; t.cd_a = xcda; t.dout_a = xa;
    t.dv_b = xvb; t.cd_b = xcdb; t.dout_b = xb;
    t.ww = xww; t.rw = xrw;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%08h expected=%08h", nm, act, exp);
    end
  endtask

  task automatic drive(input vec_t t);
    en_a = t.en_a; we_a = t.we_a; be_a = t.be_a; addr_a = t.addr_a; din_a = t.din_a;
    en_b = t.en_b; we_b = t.we_b; be_b = t.be_b; addr_b = t.addr_b; din_b = t.din_b;
  endtask

  task automatic set_a(input logic e, input logic w, input logic [3:0] b, input logic [7:0] a, input logic [31:0] d);
    en_a = e; we_a = w; be_a = b; addr_a = a; din_a = d;
    en_b = 1'b0; we_b = 1'b0; be_b = 4'h0; addr_b = 8'h00; din_b = 32'h0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //             name       ea wa ba    aa     da            eb wb bb    ab     db            va ca xa            vb cb xb            ww rw
    vecs[0]  = mk("wr10",     1, 1, 4'hF, 8'h10, 32'hDEADBEEF, 0, 0, 4'h0, 8'h00, 32'h0,        1, 0, 32'h0,        0, 1, 32'h0,        0, 0);
    vecs[1]  = mk("rd10",     0, 0, 4'h0, 8'h00, 32'h0,        1, 0, 4'h0, 8'h10, 32'h0,        0, 0, 32'h0,        1, 1, 32'hDEADBEEF, 0, 0);
    vecs[2]  = mk("pre20",    1, 1, 4'hF, 8'h20, 32'h11223344, 0, 0, 4'h0, 8'h00, 32'h0,        1, 0, 32'h0,        0, 1, 32'hDEADBEEF, 0, 0);
    vecs[3]  = mk("pre30ff",  1, 1, 4'hF, 8'h30, 32'hCCCCCCCC, 1, 1, 4'hF, 8'hFF, 32'h5,        1, 0, 32'h0,        1, 0, 32'h0,        0, 0);
    vecs[4]  = mk("be5_rdw",  1, 1, 4'h5, 8'h20, 32'hAABBCCDD, 1, 0, 4'h0, 8'h20, 32'h0,        1, 1, 32'h11223344, 1, 1, 32'h11223344, 0, 1);
    vecs[5]  = mk("rd20_30",  1, 0, 4'h0, 8'h20, 32'h0,        1, 0, 4'h0, 8'h30, 32'h0,        1, 1, 32'h11BB33DD, 1, 1, 32'hCCCCCCCC, 0, 0);
    vecs[6]  = mk("ww30",     1, 1, 4'h3, 8'h30, 32'hAAAAAAAA, 1, 1, 4'h6, 8'h30, 32'hBBBBBBBB, 1, 1, 32'hCCCCCCCC, 1, 1, 32'hCCCCCCCC, 1, 0);
    vecs[7]  = mk("rd30",     1, 0, 4'h0, 8'h30, 32'h0,        0, 0, 4'h0, 8'h00, 32'h0,        1, 1, 32'hCCBBAAAA, 0, 1, 32'hCCCCCCCC, 0, 0);
    vecs[8]  = mk("rwff",     1, 0, 4'h0, 8'hFF, 32'h0,        1, 1, 4'hF, 8'hFF, 32'h9,        1, 1, 32'h5,        1, 1, 32'h5,        0, 1);
    vecs[9]  = mk("rdff",     0, 0, 4'h0, 8'h00, 32'h0,        1, 0, 4'h0, 8'hFF, 32'h0,        0, 1, 32'h5,        1, 1, 32'h9,        0, 0);
    vecs[10] = mk("be0",      1, 1, 4'h0, 8'h20, 32'h0,        1, 0, 4'h0, 8'h20, 32'h0,        1, 1, 32'h11BB33DD, 1, 1, 32'h11BB33DD, 0, 1);
    vecs[11] = mk("rd20",     1, 0, 4'h0, 8'h20, 32'h0,        0, 0, 4'h0, 8'h00, 32'h0,        1, 1, 32'h11BB33DD, 0, 1, 32'h11BB33DD, 0, 0);
    vecs[12] = mk("rr30",     1, 0, 4'h0, 8'h30, 32'h0,        1, 0, 4'h0, 8'h30, 32'h0,        1, 1, 32'hCCBBAAAA, 1, 1, 32'hCCBBAAAA, 0, 0);
    vecs[13] = mk("idle",     0, 0, 4'h0, 8'h00, 32'h0,        0, 0, 4'h0, 8'h00, 32'h0,        0, 1, 32'hCCBBAAAA, 0, 1, 32'hCCBBAAAA, 0, 0);
    vecs[14] = mk("dis_wr",   0, 1, 4'hF, 8'h30, 32'h0,        0, 0, 4'h0, 8'h00, 32'h0,        0, 1, 32'hCCBBAAAA, 0, 1, 32'hCCBBAAAA, 0, 0);
    vecs[15] = mk("rd30b",    1, 0, 4'h0, 8'h30, 32'h0,        0, 0, 4'h0, 8'h00, 32'h0,        1, 1, 32'hCCBBAAAA, 0, 1, 32'hCCBBAAAA, 0, 0);

    rst_n = 1'b0;
    set_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    for (int c = 0; c < 4; c++) begin
      if (c == 3) rst_n = 1'b1;
      tick();
      chk($sformatf("reset%0d rf dout_a", c), rf_dout_a, 32'h0);
      chk($sformatf("reset%0d rf dout_b", c), rf_dout_b, 32'h0);
      chk($sformatf("reset%0d rf dv", c), {rf_dv_a, rf_dv_b}, 32'h0);
      chk($sformatf("reset%0d rf coll", c), {rf_ww, rf_rw}, 32'h0);
      chk($sformatf("reset%0d or dout_a", c), or_dout_a, 32'h0);
      chk($sformatf("reset%0d or dv", c), {or_dv_a, or_dv_b}, 32'h0);
    end

    for (int k = 0; k < 16; k++) begin
      drive(vecs[k]);
      tick();
      chk({vecs[k].name, " rf dvalid_a"}, rf_dv_a, vecs[k].dv_a);
      chk({vecs[k].name, " rf dvalid_b"}, rf_dv_b, vecs[k].dv_b);
      if (vecs[k].cd_a) chk({vecs[k].name, " rf dout_a"}, rf_dout_a, vecs[k].dout_a);
      if (vecs[k].cd_b) chk({vecs[k].name, " rf dout_b"}, rf_dout_b, vecs[k].dout_b);
      chk({vecs[k].name, " rf coll_ww"}, rf_ww, vecs[k].ww);
      chk({vecs[k].name, " rf coll_rw"}, rf_rw, vecs[k].rw);
      chk({vecs[k].name, " or coll_ww"}, or_ww, vecs[k].ww);
      chk({vecs[k].name, " or coll_rw"}, or_rw, vecs[k].rw);
      if (k == 0) begin
        chk("wr10 or dvalid_a", or_dv_a, 1'b0);
        chk("wr10 or dout_b", or_dout_b, 32'h0);
      end else begin
        chk({vecs[k].name, " or dvalid_a"}, or_dv_a, vecs[k-1].dv_a);
        chk({vecs[k].name, " or dvalid_b"}, or_dv_b, vecs[k-1].dv_b);
        if (vecs[k-1].cd_a) chk({vecs[k].name, " or dout_a"}, or_dout_a, vecs[k-1].dout_a);
        if (vecs[k-1].cd_b) chk({vecs[k].name, " or dout_b"}, or_dout_b, vecs[k-1].dout_b);
      end
      if (k == 4) begin
        chk("be5_rdw wf dout_a", wf_dout_a, 32'h11BB33DD);
        chk("be5_rdw wf dout_b", wf_dout_b, 32'h11223344);
        chk("be5_rdw nc dvalid_a", nc_dv_a, 1'b0);
        chk("be5_rdw nc dout_a", nc_dout_a, 32'h0);
      end
      if (k == 6) begin
        chk("ww30 wf dout_a", wf_dout_a, 32'hCCBBBBAA);
        chk("ww30 wf dout_b", wf_dout_b, 32'hCCBBBBAA);
        chk("ww30 wf coll_ww", wf_ww, 1'b1);
        chk("ww30 nc dvalid", {nc_dv_a, nc_dv_b}, 32'h0);
        chk("ww30 nc dout_a", nc_dout_a, 32'h11BB33DD);
        chk("ww30 nc dout_b", nc_dout_b, 32'hCCCCCCCC);
      end
      if (k == 7) chk("rd30 wf dout_a", wf_dout_a, 32'hCCBBBBAA);
      if (k == 10) begin
        chk("be0 wf dout_a", wf_dout_a, 32'h11BB33DD);
        chk("be0 wf dvalid_a", wf_dv_a, 1'b1);
      end
    end

    // Read in flight in the output register when reset hits; a write presented under reset must not land.
    set_a(1'b1, 1'b1, 4'hF, 8'h50, 32'hCAFEF00D);
    tick();
    set_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    tick();
    set_a(1'b1, 1'b0, 4'h0, 8'h10, 32'h0);
    tick();
    chk("inflight or dvalid_a", or_dv_a, 1'b0);
    rst_n = 1'b0;
    set_a(1'b1, 1'b1, 4'hF, 8'h50, 32'h12345678);
    tick();
    chk("rst_mid or dvalid_a", or_dv_a, 1'b0);
    chk("rst_mid or dout_a", or_dout_a, 32'h0);
    chk("rst_mid rf dout_a", rf_dout_a, 32'h0);
    rst_n = 1'b1;
    set_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    chk("post_rst or dvalid_a", or_dv_a, 1'b0);
    chk("post_rst or dout_a", or_dout_a, 32'h0);
    set_a(1'b1, 1'b0, 4'h0, 8'h50, 32'h0);
    tick();
    chk("rd50 rf dout_a", rf_dout_a, 32'hCAFEF00D);
    chk("rd50 rf dvalid_a", rf_dv_a, 1'b1);
    chk("rd50 or dvalid_a", or_dv_a, 1'b0);
    set_a(1'b0, 1'b0, 4'h0, 8'h00, 32'h0);
    tick();
    chk("rd50 or dout_a", or_dout_a, 32'hCAFEF00D);
    chk("rd50 or dvalid_a late", or_dv_a, 1'b1);
    chk("rd50 rf dvalid_a drop", rf_dv_a, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
